// File: rtl/cpipe_pkg.sv
// rtl/cpipe_pkg.sv - shared widths, bit indices and word classification for the stage-1 issue path
package cpipe_pkg;

  localparam int CPIPE_W = 9;

  localparam int CP_B0 = 0;
  localparam int CP_B1 = 1;
  localparam int CP_B2 = 2;
  localparam int CP_B3 = 3;
  localparam int CP_B4 = 4;
  localparam int CP_B5 = 5;
  localparam int CP_B6 = 6;
  localparam int CP_B7 = 7;
  localparam int CP_B8 = 8;

  localparam logic [CPIPE_W-1:0] BUBBLE_DEFAULT = 9'h000;

  // Load/store class words keep the stage busy for several cycles.
  function automatic logic is_mem_word(input logic [CPIPE_W-1:0] w);
    return w[CP_B7] & w[CP_B5] & w[CP_B4] & w[CP_B3];
  endfunction

endpackage

// File: rtl/cpipe1_fifo.sv
// rtl/cpipe1_fifo.sv - DEPTH x W synchronous FIFO with flush and combinational head
module cpipe1_fifo
  import cpipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CPIPE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpipe1_issue_stage.sv
// rtl/cpipe1_issue_stage.sv - buffers fetch control words and drives the registered CPIPE1s bus
module cpipe1_issue_stage
  import cpipe_pkg::*;
#(
  parameter int                 DEPTH       = 4,
  parameter int                 MEM_HOLD    = 2,
  parameter logic [CPIPE_W-1:0] BUBBLE_WORD = BUBBLE_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [CPIPE_W-1:0]     IWORD,
  input  logic                   IVALID,
  output logic                   IREADY,
  input  logic                   STALL,
  input  logic                   FLUSH,
  output logic [CPIPE_W-1:0]     CPIPE1s,
  output logic                   CPIPE1_VALID,
  output logic                   MEM_BUSY,
  output logic [$clog2(DEPTH):0] FIFO_COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(MEM_HOLD) + 1;

  logic [CPIPE_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               adv;
  logic               pop;
  logic [HW-1:0]      hold_cnt;

  // Ready depends on occupancy alone, so a full FIFO refuses even when popping.
  assign IREADY = (FIFO_COUNT < CW'(DEPTH));
  assign push   = IVALID & IREADY & ~FLUSH;
  assign adv    = ~STALL & ~FLUSH & (hold_cnt == '0);
  assign pop    = adv & ~fifo_empty;

  cpipe1_fifo #(
    .DEPTH (DEPTH),
    .W     (CPIPE_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .flush (FLUSH),
    .wdata (IWORD),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (FIFO_COUNT)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CPIPE1s      <= BUBBLE_WORD;
      CPIPE1_VALID <= 1'b0;
      hold_cnt     <= '0;
      MEM_BUSY     <= 1'b0;
    end else if (FLUSH) begin
      CPIPE1s      <= BUBBLE_WORD;
      CPIPE1_VALID <= 1'b0;
      hold_cnt     <= '0;
      MEM_BUSY     <= 1'b0;
    end else if (!STALL) begin
      if (hold_cnt == '0) begin
        if (!fifo_empty) begin
          CPIPE1s      <= head;
          CPIPE1_VALID <= 1'b1;
          hold_cnt     <= is_mem_word(head) ? HW'(MEM_HOLD - 1) : '0;
          MEM_BUSY     <= is_mem_word(head) && (MEM_HOLD > 1);
        end else begin
          CPIPE1s      <= BUBBLE_WORD;
          CPIPE1_VALID <= 1'b0;
        end
      end else begin
        // MEM_BUSY tracks the post-decrement count so it stays equal to hold_cnt != 0.
        hold_cnt <= hold_cnt - HW'(1);
        MEM_BUSY <= (hold_cnt != HW'(1));
      end
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_cpipe1_issue_stage.sv
// tb/tb_cpipe1_issue_stage.sv - directed self-checking bench for cpipe1_issue_stage
module tb_cpipe1_issue_stage;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [8:0] IWORD;
  logic       IVALID;
  logic       IREADY;
  logic       STALL;
  logic       FLUSH;
  logic [8:0] CPIPE1s;
  logic       CPIPE1_VALID;
  logic       MEM_BUSY;
  logic [2:0] FIFO_COUNT;

  int pass_cnt = 0;
  int total_cnt = 0;

  cpipe1_issue_stage #(.DEPTH(4), .MEM_HOLD(2), .BUBBLE_WORD(9'h000)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IWORD        (IWORD),
    .IVALID       (IVALID),
    .IREADY       (IREADY),
    .STALL        (STALL),
    .FLUSH        (FLUSH),
    .CPIPE1s      (CPIPE1s),
    .CPIPE1_VALID (CPIPE1_VALID),
    .MEM_BUSY     (MEM_BUSY),
    .FIFO_COUNT   (FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IWORD = '0; IVALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    #1;
    total_cnt++; if (CPIPE1s !== 9'h000) $display("FAIL reset_word got %h want 000", CPIPE1s); else pass_cnt++;
    total_cnt++; if (CPIPE1_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", CPIPE1_VALID); else pass_cnt++;
    total_cnt++; if (FIFO_COUNT !== 3'd0) $display("FAIL reset_count got %0d want 0", FIFO_COUNT); else pass_cnt++;
    total_cnt++; if (MEM_BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", MEM_BUSY); else pass_cnt++;
    total_cnt++; if (IREADY !== 1'b1) $display("FAIL reset_iready got %b want 1", IREADY); else pass_cnt++;
    tick(); tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] w [3];
    logic [8:0] exp_w [5];
    logic       exp_v [5];
    logic [2:0] exp_c [5];
    w = '{9'h0A5, 9'h0A4, 9'h0A7};
    exp_w = '{9'h000, 9'h0A5, 9'h0A4, 9'h0A7, 9'h000};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_c = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin IVALID = 1'b1; IWORD = w[i]; end
      else IVALID = 1'b0;
      tick();
      total_cnt++; if (CPIPE1s !== exp_w[i]) $display("FAIL b2b_word[%0d] got %h want %h", i, CPIPE1s, exp_w[i]); else pass_cnt++;
      total_cnt++; if (CPIPE1_VALID !== exp_v[i]) $display("FAIL b2b_valid[%0d] got %b want %b", i, CPIPE1_VALID, exp_v[i]); else pass_cnt++;
      total_cnt++; if (FIFO_COUNT !== exp_c[i]) $display("FAIL b2b_count[%0d] got %0d want %0d", i, FIFO_COUNT, exp_c[i]); else pass_cnt++;
    end
  endtask

  task automatic test_mem_hold();
    logic [8:0] exp_w [5];
    logic       exp_v [5];
    logic       exp_b [5];
    exp_w = '{9'h000, 9'h0B8, 9'h0B8, 9'h0A5, 9'h000};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin IVALID = 1'b1; IWORD = 9'h0B8; end
      else if (i == 1) begin IVALID = 1'b1; IWORD = 9'h0A5; end
      else IVALID = 1'b0;
      tick();
      total_cnt++; if (CPIPE1s !== exp_w[i]) $display("FAIL mem_word[%0d] got %h want %h", i, CPIPE1s, exp_w[i]); else pass_cnt++;
      total_cnt++; if (CPIPE1_VALID !== exp_v[i]) $display("FAIL mem_valid[%0d] got %b want %b", i, CPIPE1_VALID, exp_v[i]); else pass_cnt++;
      total_cnt++; if (MEM_BUSY !== exp_b[i]) $display("FAIL mem_busy[%0d] got %b want %b", i, MEM_BUSY, exp_b[i]); else pass_cnt++;
    end
  endtask

  task automatic test_mem_stall();
    int occ = 0;
    IVALID = 1'b1; IWORD = 9'h0B8;
    tick();
    IVALID = 1'b0;
    for (int i = 0; i < 7; i++) begin
      STALL = (i >= 1 && i <= 3);
      tick();
      if (CPIPE1s === 9'h0B8 && CPIPE1_VALID === 1'b1) occ++;
      if (i >= 1 && i <= 3) begin
        total_cnt++; if (MEM_BUSY !== 1'b1) $display("FAIL mstall_busy[%0d] got %b want 1", i, MEM_BUSY); else pass_cnt++;
      end
    end
    STALL = 1'b0;
    total_cnt++; if (occ != 5) $display("FAIL mstall_occupancy got %0d want 5", occ); else pass_cnt++;
    total_cnt++; if (CPIPE1_VALID !== 1'b0) $display("FAIL mstall_end_valid got %b want 0", CPIPE1_VALID); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [8:0] w [4];
    w = '{9'h011, 9'h022, 9'h033, 9'h044};
    STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IVALID = 1'b1; IWORD = w[i];
      tick();
      total_cnt++; if (FIFO_COUNT !== 3'(i + 1)) $display("FAIL full_count[%0d] got %0d want %0d", i, FIFO_COUNT, i + 1); else pass_cnt++;
    end
    total_cnt++; if (IREADY !== 1'b0) $display("FAIL full_iready got %b want 0", IREADY); else pass_cnt++;
    IWORD = 9'h055;
    tick();
    total_cnt++; if (FIFO_COUNT !== 3'd4) $display("FAIL full_fifth got %0d want 4", FIFO_COUNT); else pass_cnt++;
    IVALID = 1'b0; STALL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        total_cnt++; if (CPIPE1s !== w[i] || CPIPE1_VALID !== 1'b1) $display("FAIL full_drain[%0d] got %h/%b want %h/1", i, CPIPE1s, CPIPE1_VALID, w[i]); else pass_cnt++;
      end else begin
        total_cnt++; if (CPIPE1_VALID !== 1'b0) $display("FAIL full_after got valid %b want 0", CPIPE1_VALID); else pass_cnt++;
      end
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IVALID = 1'b1; IWORD = 9'(9'h101 + i);
      tick();
    end
    total_cnt++; if (FIFO_COUNT !== 3'd3) $display("FAIL flush_pre_count got %0d want 3", FIFO_COUNT); else pass_cnt++;
    FLUSH = 1'b1; IWORD = 9'h1FF;
    tick();
    FLUSH = 1'b0; IVALID = 1'b0;
    total_cnt++; if (FIFO_COUNT !== 3'd0) $display("FAIL flush_count got %0d want 0", FIFO_COUNT); else pass_cnt++;
    total_cnt++; if (CPIPE1_VALID !== 1'b0) $display("FAIL flush_valid got %b want 0", CPIPE1_VALID); else pass_cnt++;
    total_cnt++; if (CPIPE1s !== 9'h000) $display("FAIL flush_word got %h want 000", CPIPE1s); else pass_cnt++;
    STALL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (CPIPE1_VALID === 1'b1) seen++;
    end
    total_cnt++; if (seen != 0) $display("FAIL flush_leak got %0d issued want 0", seen); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [8:0] rec [$];
    logic [8:0] last = 9'h000;
    int idx = 0;
    int over = 0;
    for (int cyc = 0; cyc < 200 && rec.size() < 10; cyc++) begin
      STALL = ($urandom_range(0, 2) == 0);
      if (idx < 10) begin
        IVALID = 1'b1; IWORD = 9'(9'h040 + idx);
        if (IREADY === 1'b1) idx++;
      end else IVALID = 1'b0;
      tick();
      if (FIFO_COUNT > 3'd4) over++;
      if (CPIPE1_VALID === 1'b1 && CPIPE1s !== last) begin
        rec.push_back(CPIPE1s);
        last = CPIPE1s;
      end
    end
    IVALID = 1'b0; STALL = 1'b0;
    tick(); tick();
    total_cnt++; if (rec.size() != 10) $display("FAIL wrap_received got %0d want 10", rec.size()); else pass_cnt++;
    for (int i = 0; i < 10 && i < rec.size(); i++) begin
      total_cnt++; if (rec[i] !== 9'(9'h040 + i)) $display("FAIL wrap_order[%0d] got %h want %h", i, rec[i], 9'(9'h040 + i)); else pass_cnt++;
    end
    total_cnt++; if (over != 0) $display("FAIL wrap_overfill got %0d cycles want 0", over); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    IVALID = 1'b1; IWORD = 9'h0B8;
    tick();
    IVALID = 1'b0;
    tick();
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IVALID = 1'b1; IWORD = 9'(9'h021 + i);
      tick();
    end
    IVALID = 1'b0;
    total_cnt++; if (FIFO_COUNT !== 3'd3 || MEM_BUSY !== 1'b1) $display("FAIL rstm_pre got count %0d busy %b want 3/1", FIFO_COUNT, MEM_BUSY); else pass_cnt++;
    #2;
    RESET = 1'b1;
    #1;
    total_cnt++; if (CPIPE1s !== 9'h000) $display("FAIL rstm_word got %h want 000", CPIPE1s); else pass_cnt++;
    total_cnt++; if (CPIPE1_VALID !== 1'b0) $display("FAIL rstm_valid got %b want 0", CPIPE1_VALID); else pass_cnt++;
    total_cnt++; if (FIFO_COUNT !== 3'd0) $display("FAIL rstm_count got %0d want 0", FIFO_COUNT); else pass_cnt++;
    total_cnt++; if (MEM_BUSY !== 1'b0) $display("FAIL rstm_busy got %b want 0", MEM_BUSY); else pass_cnt++;
    tick();
    RESET = 1'b0; STALL = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mem_hold();
    test_mem_stall();
    test_full();
    test_flush();
    test_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
